// File: rtl/vga_pkg.sv
// Shared VGA constants and start-screen state encoding.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COL_W    = 8;

  typedef enum logic [1:0] {ATTRACT = 2'd0, CONFIRM = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb_t;

  // Counter width for a count range of n values, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for the raw start button.
// Flops reset high so a button held through reset never looks like a press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  logic s1, s2, prev;

  // Synchronize, then keep one more stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
endmodule

// File: rtl/start_screen_mixer.sv
// Start-screen banner compositor: hit test, blink control, attract/confirm/done
// FSM and a one-cycle registered output stage.
module start_screen_mixer
  import vga_pkg::*;
#(
  parameter int SPR_W          = 160,
  parameter int SPR_H          = 32,
  parameter int SPR_X0         = 240,
  parameter int SPR_Y0         = 224,
  parameter int BLINK_FRAMES   = 30,
  parameter int FAST_FRAMES    = 4,
  parameter int CONFIRM_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             de,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             frame_start,
  input  logic             btn_start,
  input  logic             game_over,
  input  logic [COL_W-1:0] bg_r,
  input  logic [COL_W-1:0] bg_g,
  input  logic [COL_W-1:0] bg_b,
  output logic [9:0]       spr_x,
  output logic [9:0]       spr_y,
  input  logic [COL_W-1:0] spr_r,
  input  logic [COL_W-1:0] spr_g,
  input  logic [COL_W-1:0] spr_b,
  input  logic             spr_a,
  output logic [COL_W-1:0] vga_r,
  output logic [COL_W-1:0] vga_g,
  output logic [COL_W-1:0] vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic             overlay_active,
  output logic             game_start
);
  localparam int CNT_W = cnt_w((BLINK_FRAMES > CONFIRM_FRAMES) ? BLINK_FRAMES : CONFIRM_FRAMES);
  localparam int TOG_W = cnt_w(FAST_FRAMES);

  localparam logic [9:0]       X0 = 10'(SPR_X0);
  localparam logic [9:0]       X1 = 10'(SPR_X0 + SPR_W);
  localparam logic [9:0]       Y0 = 10'(SPR_Y0);
  localparam logic [9:0]       Y1 = 10'(SPR_Y0 + SPR_H);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CONF_LAST  = CNT_W'(CONFIRM_FRAMES - 1);
  localparam logic [TOG_W-1:0] FAST_LAST  = TOG_W'(FAST_FRAMES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [TOG_W-1:0] tcnt_q, tcnt_d;
  logic             vis_q, vis_d;
  logic             gs_d;
  logic             btn_rise;
  logic             hit, show;
  rgb_t             spr_c, bg_c, pix_q;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .rise  (btn_rise)
  );

  // Banner hit test and local coordinates; zero outside the banner.
  assign hit   = de && (pixel_x >= X0) && (pixel_x < X1) && (pixel_y >= Y0) && (pixel_y < Y1);
  assign spr_x = hit ? pixel_x - X0 : 10'd0;
  assign spr_y = hit ? pixel_y - Y0 : 10'd0;

  assign overlay_active = (state_q != DONE);

  // FSM, frame counters and visibility state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ATTRACT;
      fcnt_q     <= '0;
      tcnt_q     <= '0;
      vis_q      <= 1'b1;
      game_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      tcnt_q     <= tcnt_d;
      vis_q      <= vis_d;
      game_start <= gs_d;
    end
  end

  // Next state: a button edge beats a coincident blink tick in ATTRACT.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    vis_d   = vis_q;
    gs_d    = 1'b0;
    case (state_q)
      ATTRACT: begin
        if (btn_rise) begin
          state_d = CONFIRM;
          fcnt_d  = '0;
          tcnt_d  = '0;
          vis_d   = 1'b1;
        end else if (frame_start) begin
          if (fcnt_q == BLINK_LAST) begin
            fcnt_d = '0;
            vis_d  = ~vis_q;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      CONFIRM: begin
        if (frame_start) begin
          if (fcnt_q == CONF_LAST) begin
            state_d = DONE;
            gs_d    = 1'b1;
            vis_d   = 1'b0;
            fcnt_d  = '0;
            tcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
            if (tcnt_q == FAST_LAST) begin
              tcnt_d = '0;
              vis_d  = ~vis_q;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (game_over) begin
          state_d = ATTRACT;
          fcnt_d  = '0;
          tcnt_d  = '0;
          vis_d   = 1'b1;
        end
      end
      default: state_d = ATTRACT;
    endcase
  end

  assign spr_c = '{r: spr_r, g: spr_g, b: spr_b};
  assign bg_c  = '{r: bg_r,  g: bg_g,  b: bg_b};
  assign show  = hit && spr_a && vis_q && overlay_active;

  // One-cycle output stage: colour mux plus delayed syncs and de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q  <= '0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else begin
      pix_q  <= !de ? rgb_t'('0) : (show ? spr_c : bg_c);
      vga_hs <= hsync_in;
      vga_vs <= vsync_in;
      vga_de <= de;
    end
  end

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;
endmodule

// File: tb/tb_start_screen_mixer.sv
// Directed bench for start_screen_mixer: table of pixel vectors plus
// hand-written blink / confirm / done / reset sequences.
module tb_start_screen_mixer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       de = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic       frame_start = 1'b0, btn_start = 1'b0, game_over = 1'b0;
  logic [7:0] bg_r = '0, bg_g = '0, bg_b = '0;
  logic [7:0] spr_r = '0, spr_g = '0, spr_b = '0;
  logic       spr_a = 1'b0;
  logic [9:0] spr_x, spr_y;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de, overlay_active, game_start;

  int errs = 0, checks = 0, gs_cnt = 0, gs_base;

  start_screen_mixer dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .btn_start(btn_start), .game_over(game_over),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .spr_x(spr_x), .spr_y(spr_y),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_a(spr_a),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .overlay_active(overlay_active), .game_start(game_start)
  );

  always #5 clk = ~clk;

  // Count every cycle game_start is seen high.
  always @(negedge clk) if (game_start) gs_cnt++;

  typedef struct {
    logic [9:0]  x, y;
    logic        de, hs, vs, a;
    logic [23:0] srgb, bg;
    logic [9:0]  ex, ey;
    logic [23:0] ergb;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
    #1;
  endtask

  task automatic drive_banner();
    pixel_x = 10'd320; pixel_y = 10'd240; de = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    spr_a = 1'b1; {spr_r, spr_g, spr_b} = 24'hFFFFFF; {bg_r, bg_g, bg_b} = 24'h000020;
  endtask

  // Drive a centre-of-banner pixel and check whether the sprite shows.
  task automatic pix(input string name, input bit show);
    @(negedge clk) drive_banner();
    @(negedge clk) #1;
    chk(name, {8'h0, vga_r, vga_g, vga_b}, show ? 32'hFFFFFF : 32'h000020);
  endtask

  task automatic do_reset(input logic hold);
    @(negedge clk) rst_n = 1'b0; btn_start = hold;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{10'd320, 10'd240, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 24'h000020, 10'd80,  10'd16, 24'hFFFFFF};
    tbl[1] = '{10'd239, 10'd240, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'h000020, 10'd0,   10'd0,  24'h000020};
    tbl[2] = '{10'd399, 10'd255, 1'b1, 1'b1, 1'b1, 1'b1, 24'h12AB34, 24'h000020, 10'd159, 10'd31, 24'h12AB34};
    tbl[3] = '{10'd400, 10'd240, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'h000020, 10'd0,   10'd0,  24'h000020};
    tbl[4] = '{10'd320, 10'd256, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 24'h000020, 10'd0,   10'd0,  24'h000020};
    tbl[5] = '{10'd320, 10'd240, 1'b0, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'h000020, 10'd0,   10'd0,  24'h000000};
    tbl[6] = '{10'd240, 10'd224, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, 24'h445566, 10'd0,   10'd0,  24'h445566};
    tbl[7] = '{10'd240, 10'd224, 1'b1, 1'b0, 1'b0, 1'b1, 24'hA1B2C3, 24'h445566, 10'd0,   10'd0,  24'hA1B2C3};
    tbl[8] = '{10'd320, 10'd223, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'h778899, 10'd0,   10'd0,  24'h778899};

    // Reset values, with live inputs that must not leak through.
    drive_banner();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rgb",  {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("reset_sync", {29'h0, vga_hs, vga_vs, vga_de}, 32'h0);
    chk("reset_ovl",  {30'h0, overlay_active, game_start}, 32'h2);
    @(negedge clk) rst_n = 1'b1;

    // Table of single pixels in ATTRACT with banner visible.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pixel_x = tbl[i].x; pixel_y = tbl[i].y; de = tbl[i].de;
      hsync_in = tbl[i].hs; vsync_in = tbl[i].vs; spr_a = tbl[i].a;
      {spr_r, spr_g, spr_b} = tbl[i].srgb; {bg_r, bg_g, bg_b} = tbl[i].bg;
      #1;
      chk($sformatf("vec%0d_sprxy", i), {12'h0, spr_x, spr_y}, {12'h0, tbl[i].ex, tbl[i].ey});
      @(negedge clk) #1;
      chk($sformatf("vec%0d_rgb", i), {8'h0, vga_r, vga_g, vga_b}, {8'h0, tbl[i].ergb});
      chk($sformatf("vec%0d_sync", i), {29'h0, vga_hs, vga_vs, vga_de}, {29'h0, tbl[i].hs, tbl[i].vs, tbl[i].de});
    end

    // Slow blink in ATTRACT.
    pix("attract_vis0", 1'b1);
    frames(29);
    pix("attract_29", 1'b1);
    frames(1);
    pix("attract_30", 1'b0);
    frames(30);
    pix("attract_60", 1'b1);
    @(negedge clk) spr_a = 1'b0;
    @(negedge clk) #1;
    chk("alpha0_bg", {8'h0, vga_r, vga_g, vga_b}, 32'h000020);

    // Button held through reset must not start CONFIRM.
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    frames(4);
    pix("held_btn_no_confirm", 1'b1);
    frames(25);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
    // Press so the synchronized edge lands on a frame_start that would blink.
    drive_banner();
    @(negedge clk) btn_start = 1'b1;
    @(negedge clk);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk) #1;
    chk("edge_beats_blink", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);

    // Fast blink in CONFIRM, then the game_start pulse.
    gs_base = gs_cnt;
    frames(3);
    pix("confirm_3", 1'b1);
    frames(1);
    pix("confirm_4", 1'b0);
    frames(4);
    pix("confirm_8", 1'b1);
    frames(51);
    chk("no_gs_before_60", gs_cnt - gs_base, 0);
    chk("ovl_in_confirm", {31'h0, overlay_active}, 1);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    #1;
    chk("gs_pulse", {31'h0, game_start}, 1);
    chk("ovl_done", {31'h0, overlay_active}, 0);
    @(negedge clk) #1;
    chk("gs_one_cycle", {31'h0, game_start}, 0);
    chk("gs_count", gs_cnt - gs_base, 1);

    // DONE: background only, button ignored.
    pix("done_bg", 1'b0);
    btn_start = 1'b0;
    repeat (4) @(negedge clk);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("done_btn_ignored", {31'h0, overlay_active}, 0);
    pix("done_bg2", 1'b0);
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    #1;
    chk("game_over_attract", {31'h0, overlay_active}, 1);
    pix("after_game_over", 1'b1);

    // Reset in the middle of CONFIRM.
    btn_start = 1'b0;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
    frames(28);
    pix("confirm_28_hidden", 1'b0);
    frames(2);
    gs_base = gs_cnt;
    drive_banner();
    @(negedge clk) #2;
    chk("pre_reset_active", {29'h0, vga_hs, vga_vs, vga_de}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb",  {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("midrst_sync", {29'h0, vga_hs, vga_vs, vga_de}, 32'h0);
    chk("midrst_ovl",  {30'h0, overlay_active, game_start}, 32'h2);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    frames(4);
    pix("post_reset_attract", 1'b1);
    frames(36);
    pix("post_reset_blink", 1'b0);
    chk("no_gs_after_reset", gs_cnt - gs_base, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
